// File: rtl/ab_pattern_tx_if.sv
// ab_pattern_tx_if: frame request / serial A-B output bundle for ab_pattern_tx.
// LW is derived from WIDTH and is not meant to be overridden.
interface ab_pattern_tx_if #(
  parameter int WIDTH = 8
);
  localparam int LW = $clog2(WIDTH) + 1;

  logic             START;
  logic [WIDTH-1:0] DATA_A;
  logic [WIDTH-1:0] DATA_B;
  logic [LW-1:0]    LEN;
  logic             A;
  logic             B;
  logic             VALID;
  logic             BUSY;
  logic             DONE;

  // Frame source side (bench / upstream controller)
  modport master (
    output START, DATA_A, DATA_B, LEN,
    input  A, B, VALID, BUSY, DONE
  );

  // Transmitter side
  modport slave (
    input  START, DATA_A, DATA_B, LEN,
    output A, B, VALID, BUSY, DONE
  );
endinterface

// File: rtl/ab_pattern_tx.sv
// ab_pattern_tx: loads an A/B frame on START and shifts it out LSB-first,
// one bit pair per clock, with VALID qualifier and a one-cycle DONE pulse.
// Optional feature macro: AB_TX_PARITY_EN adds one even-parity VALID cycle
// (parity of sent A bits on A, of sent B bits on B) before DONE.
module ab_pattern_tx #(
  parameter int WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  ab_pattern_tx_if.slave bus
);
  localparam int LW = $clog2(WIDTH) + 1;

`ifdef AB_TX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    FIN   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    n_q, n_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef AB_TX_PARITY_EN
  logic             pa_a_q, pa_a_d;
  logic             pa_b_q, pa_b_d;
`endif

  // Next-state, datapath update and next output values.
  // Outputs are decoded from the *next* state so they land in flops and
  // the cycle after an edge shows what that state presents.
  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
`ifdef AB_TX_PARITY_EN
    pa_a_d  = pa_a_q;
    pa_b_d  = pa_b_q;
`endif
    a_d     = 1'b0;
    b_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          sh_a_d = bus.DATA_A;
          sh_b_d = bus.DATA_B;
          if ((bus.LEN == '0) || (bus.LEN > LW'(WIDTH))) begin
            n_d = LW'(WIDTH);
          end else begin
            n_d = bus.LEN;
          end
          cnt_d = '0;
`ifdef AB_TX_PARITY_EN
          pa_a_d = 1'b0;
          pa_b_d = 1'b0;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_a_d = sh_a_q >> 1;
        sh_b_d = sh_b_q >> 1;
        cnt_d  = cnt_q + LW'(1);
`ifdef AB_TX_PARITY_EN
        pa_a_d = pa_a_q ^ sh_a_q[0];
        pa_b_d = pa_b_q ^ sh_b_q[0];
`endif
        if (cnt_q == (n_q - LW'(1))) begin
`ifdef AB_TX_PARITY_EN
          state_d = PAR;
`else
          state_d = FIN;
`endif
        end
      end
`ifdef AB_TX_PARITY_EN
      PAR: begin
        state_d = FIN;
      end
`endif
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      SHIFT: begin
        a_d     = sh_a_d[0];
        b_d     = sh_b_d[0];
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
`ifdef AB_TX_PARITY_EN
      PAR: begin
        a_d     = pa_a_d;
        b_d     = pa_b_d;
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
`endif
      FIN: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
`ifdef AB_TX_PARITY_EN
      pa_a_q  <= 1'b0;
      pa_b_q  <= 1'b0;
`endif
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
`ifdef AB_TX_PARITY_EN
      pa_a_q  <= pa_a_d;
      pa_b_q  <= pa_b_d;
`endif
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.A     = a_q;
  assign bus.B     = b_q;
  assign bus.VALID = valid_q;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;

endmodule
